// File: rtl/writeback_regfile_pkg.sv
// Shared sizing, the hardwired-zero index and the pending-write record
// used by the write-back register bank.
package writeback_regfile_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int ADDR_WIDTH = 3;
  localparam int NUM_REGS   = 8;

  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } pend_t;

endpackage

// File: rtl/writeback_regfile_reg_word.sv
// One DATA_WIDTH storage word with async clear; loads on i_we at the rising edge.
// Zero latency to o_q after the edge; no backpressure.
module reg_word
  import writeback_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_q <= '0;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/writeback_regfile.sv
// Write-back pending stage plus 8x4 register bank; writes land in the array one edge
// after capture, reads bypass the pending entry; enable=0 freezes all state.
module writeback_regfile
  import writeback_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  pend_valid
);

  pend_t                 r_pend;
  logic [NUM_REGS-1:1]   w_we;
  logic [DATA_WIDTH-1:0] w_word [NUM_REGS];
  logic                  w_hit1;
  logic                  w_hit2;

  // Writes to index 0 are dropped here so they never reach the bypass or the array.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_pend <= '0;
    end else if (enable) begin
      r_pend.valid <= wb_valid && (wb_addr != ZERO_REG);
      r_pend.addr  <= wb_addr;
      r_pend.data  <= wb_data;
    end
  end

  always_comb begin
    w_we = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_we[i] = enable && r_pend.valid && (r_pend.addr == ADDR_WIDTH'(i));
    end
  end

  assign w_word[0] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_word
    reg_word u_word (
      .clk   (clk),
      .clear (clear),
      .i_we  (w_we[g]),
      .i_d   (r_pend.data),
      .o_q   (w_word[g])
    );
  end

  assign w_hit1 = r_pend.valid && (rs1_addr == r_pend.addr);
  assign w_hit2 = r_pend.valid && (rs2_addr == r_pend.addr);

  assign rs1_data   = w_hit1 ? r_pend.data : w_word[rs1_addr];
  assign rs2_data   = w_hit2 ? r_pend.data : w_word[rs2_addr];
  assign pend_valid = r_pend.valid;

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: vector table through a scoreboard queue, reset
// corner sequences, then a randomized phase against a behavioural model.
module tb_writeback_regfile;

  logic       clk = 1'b0;
  logic       clear;
  logic       enable;
  logic       wb_valid;
  logic [2:0] wb_addr;
  logic [3:0] wb_data;
  logic [2:0] rs1_addr;
  logic [2:0] rs2_addr;
  logic [3:0] rs1_data;
  logic [3:0] rs2_data;
  logic       pend_valid;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       en;
    logic       v;
    logic [2:0] a;
    logic [3:0] d;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [3:0] e1;
    logic [3:0] e2;
    logic       ep;
  } vec_t;

  typedef struct {
    logic [3:0] e1;
    logic [3:0] e2;
    logic       ep;
  } exp_t;

  vec_t vecs [13];
  exp_t sb_q [$];

  writeback_regfile dut (
    .clk        (clk),
    .clear      (clear),
    .enable     (enable),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .pend_valid (pend_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic v, input logic [2:0] a, input logic [3:0] d,
                       input logic [2:0] r1, input logic [2:0] r2);
    enable   = en;
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
    rs1_addr = r1;
    rs2_addr = r2;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      rs1_addr = 3'(i);
      rs2_addr = 3'(7 - i);
      #1;
      check({tag, "_rs1"}, {28'd0, rs1_data}, 32'd0);
      check({tag, "_rs2"}, {28'd0, rs2_data}, 32'd0);
    end
  endtask

  // Reference model state for the randomized phase.
  logic [3:0] m_mem [8];
  logic       m_pv;
  logic [2:0] m_pa;
  logic [3:0] m_pd;

  function automatic logic [3:0] m_read(input logic [2:0] r);
    if (m_pv && r == m_pa) return m_pd;
    return m_mem[r];
  endfunction

  initial begin
    exp_t e;

    //            en  v  a  d     r1 r2 e1    e2    ep
    vecs[0]  = '{1, 1, 3, 4'hA, 3, 0, 4'hA, 4'h0, 1};
    vecs[1]  = '{1, 0, 3, 4'h5, 3, 3, 4'hA, 4'hA, 0};
    vecs[2]  = '{1, 1, 0, 4'hF, 0, 3, 4'h0, 4'hA, 0};
    vecs[3]  = '{1, 1, 5, 4'h6, 0, 5, 4'h0, 4'h6, 1};
    vecs[4]  = '{0, 1, 5, 4'h9, 3, 5, 4'hA, 4'h6, 1};
    vecs[5]  = '{0, 1, 5, 4'h9, 3, 5, 4'hA, 4'h6, 1};
    vecs[6]  = '{0, 1, 5, 4'h9, 3, 5, 4'hA, 4'h6, 1};
    vecs[7]  = '{1, 1, 5, 4'h9, 3, 5, 4'hA, 4'h9, 1};
    vecs[8]  = '{1, 1, 2, 4'h1, 2, 5, 4'h1, 4'h9, 1};
    vecs[9]  = '{1, 1, 2, 4'h7, 2, 2, 4'h7, 4'h7, 1};
    vecs[10] = '{1, 0, 2, 4'h0, 2, 5, 4'h7, 4'h9, 0};
    vecs[11] = '{1, 1, 7, 4'h3, 7, 7, 4'h3, 4'h3, 1};
    vecs[12] = '{1, 0, 0, 4'h0, 7, 1, 4'h3, 4'h0, 0};

    drive(1'b0, 1'b0, 3'd0, 4'd0, 3'd0, 3'd0);
    clear = 1'b1;
    #1;
    check("reset_pend", {31'd0, pend_valid}, 32'd0);
    check_all_zero("reset");
    step();
    clear = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].en, vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].r1, vecs[i].r2);
      sb_q.push_back('{vecs[i].e1, vecs[i].e2, vecs[i].ep});
      step();
      e = sb_q.pop_front();
      check($sformatf("vec%0d_rs1", i), {28'd0, rs1_data}, {28'd0, e.e1});
      check($sformatf("vec%0d_rs2", i), {28'd0, rs2_data}, {28'd0, e.e2});
      check($sformatf("vec%0d_pend", i), {31'd0, pend_valid}, {31'd0, e.ep});
    end

    // Incoming wb_data must not be visible before the capture edge.
    drive(1'b1, 1'b1, 3'd6, 4'h5, 3'd6, 3'd6);
    #1;
    check("nobypass_pre_edge", {28'd0, rs1_data}, 32'd0);
    step();
    check("nobypass_post_edge", {28'd0, rs1_data}, 32'h5);

    // Capture a write, then clear before it can commit.
    drive(1'b1, 1'b1, 3'd4, 4'hC, 3'd4, 3'd2);
    step();
    check("midrst_pend_before", {31'd0, pend_valid}, 32'd1);
    check("midrst_bypass_before", {28'd0, rs1_data}, 32'hC);
    wb_valid = 1'b0;
    clear = 1'b1;
    #1;
    check("midrst_pend_async", {31'd0, pend_valid}, 32'd0);
    check_all_zero("midrst");
    step();
    clear = 1'b0;
    rs1_addr = 3'd4;
    step();
    check("midrst_word4_a", {28'd0, rs1_data}, 32'd0);
    check("midrst_pend_after", {31'd0, pend_valid}, 32'd0);
    step();
    check("midrst_word4_b", {28'd0, rs1_data}, 32'd0);

    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_pv = 1'b0;
    m_pa = '0;
    m_pd = '0;
    for (int n = 0; n < 60; n++) begin
      logic       en, v;
      logic [2:0] a, r1, r2;
      logic [3:0] d;
      en = ($urandom_range(0, 3) != 0);
      v  = $urandom_range(0, 1) == 1;
      a  = 3'($urandom_range(0, 7));
      d  = 4'($urandom_range(0, 15));
      r1 = 3'($urandom_range(0, 7));
      r2 = (n % 4 == 0) ? r1 : 3'($urandom_range(0, 7));
      drive(en, v, a, d, r1, r2);
      if (en) begin
        if (m_pv) m_mem[m_pa] = m_pd;
        m_pv = v && (a != 3'd0);
        m_pa = a;
        m_pd = d;
      end
      sb_q.push_back('{m_read(r1), m_read(r2), m_pv});
      step();
      e = sb_q.pop_front();
      check($sformatf("rnd%0d_rs1", n), {28'd0, rs1_data}, {28'd0, e.e1});
      check($sformatf("rnd%0d_rs2", n), {28'd0, rs2_data}, {28'd0, e.e2});
      check($sformatf("rnd%0d_pend", n), {31'd0, pend_valid}, {31'd0, e.ep});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Write-back stage plus register bank for the gate-level RISC-V datapath.
- Sits directly upstream of the 4-bit register storage cells. It accepts the ALU/load result and destination index, holds them for one stage, then drives per-word enable/data into the storage array.
- Provides two combinational read ports with bypass from the pending write, so decode sees the newest value.

Parameters:
- DATA_WIDTH, 4, bits per register word.
- ADDR_WIDTH, 3, register index width.
- NUM_REGS, 8, number of words; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  single system clock, rising edge.
- clear  input  1  asynchronous, active-high reset.
- enable  input  1  global advance; 0 = stall, all state holds.
- wb_valid  input  1  write request present this cycle.
- wb_addr  input  ADDR_WIDTH  destination register index.
- wb_data  input  DATA_WIDTH  value to write.
- rs1_addr  input  ADDR_WIDTH  read port A index.
- rs2_addr  input  ADDR_WIDTH  read port B index.
- rs1_data  output  DATA_WIDTH  read port A value.
- rs2_data  output  DATA_WIDTH  read port B value.
- pend_valid  output  1  pending-write stage occupied.

Behaviour:
- Reset (clear=1, async, no clk needed):
  - all NUM_REGS words = 0
  - pend_valid = 0, pend_addr = 0, pend_data = 0
  - rs1_data/rs2_data therefore read 0
  - a pending write in flight at assertion is discarded, never committed.
- Pipeline, two stages. Each rising edge with enable=1 and clear=0:
  - commit: if pend_valid, word[pend_addr] <= pend_data.
  - capture: pend_valid <= wb_valid && (wb_addr != 0); pend_addr <= wb_addr; pend_data <= wb_data.
  - Commit and capture happen on the same edge; the old pending entry commits and the new request is captured.
- Write latency:
  - request at edge N is visible on reads (via bypass) after edge N.
  - request is in the array after edge N+1.
- enable=0: no commit, no capture; wb inputs ignored; pending entry and array hold indefinitely.
- Register 0:
  - writes to index 0 are dropped at capture, so pend_valid stays 0.
  - reads of index 0 always return 0.
- Read ports:
  - purely combinational, no clock latency.
  - if pend_valid and rsX_addr == pend_addr, return pend_data; else return word[rsX_addr].
  - incoming wb_data of the current cycle is NOT bypassed.
- Both ports may address the same word; each returns an identical value.
- Back-to-back writes to the same index on consecutive edges: first commits while second is captured; reads return the second value after the second edge.
- No overflow or width arithmetic; data passes unmodified, DATA_WIDTH bits.

Decomposition:
- Shared package holds:
  - DATA_WIDTH, ADDR_WIDTH, NUM_REGS
  - ZERO_REG = 0
  - pending-entry record type: valid, addr, data.
- One natural sub-module: reg_word.
  - DATA_WIDTH storage word with clk, async clear, write enable.
  - Instantiated NUM_REGS-1 times; index 0 is hardwired zero, no storage.
  - Top level contains the pending stage, write decoder (pend_addr -> one-hot word enable gated by pend_valid and enable), and the two bypass read muxes.

Test Plan:
- Reset then read all indices.
  - clear=1 mid-run -> rs1_data=rs2_data=0 for indices 0..7; pend_valid=0 immediately, before any clk edge.
- Basic write and bypass.
  - wb_valid=1, wb_addr=3, wb_data=4'hA at edge N, then wb_valid=0; rs1_addr=3.
  - rs1_data=A after edge N (bypass, pend_valid=1); still A after edge N+1 (array, pend_valid=0).
- Register 0.
  - write addr=0, data=4'hF -> pend_valid stays 0; rs1_data for addr 0 = 0 on all cycles.
- Stall.
  - write addr=5, data=4'h6 captured; enable=0 for 3 edges, with wb_valid=1, addr=5, data=4'h9 presented.
  - pend_valid=1 and rs2_data=6 throughout.
  - On enable=1: commits 6 and captures 9; rs2_data=9 afterwards.
- Back-to-back same index.
  - writes addr=2 data=1, then addr=2 data=7 on consecutive edges -> rs1_data=1, then 7; array word2=7 after third edge.
- Reset mid-operation.
  - capture addr=4, data=4'hC, then assert clear before the commit edge -> word4=0 and pend_valid=0 after release; no later commit of C.
